alu_exec_ctrl: RTL and testbench

//  Execution engine between the instruction FIFO, operand register file and result FIFO of the ALU

---
 rtl/alu_exec_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_exec_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// ALU execution engine: drains the instruction FIFO, reads two operands,
// computes one result per instruction and pushes it to the result FIFO.
module alu_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_begin,
  input  logic              inst_empty,
  input  logic [DATA_W-1:0] inst_dout,
  output logic              inst_rd_en,
  output logic              re,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [DATA_W-1:0] rData,
  input  logic              r_full,
  output logic              r_wr_en,
  output logic [DATA_W-1:0] r_din,
  output logic              op_done
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_POP    = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_RD_A   = 4'd3;
  localparam logic [3:0] S_RD_B   = 4'd4;
  localparam logic [3:0] S_EXEC   = 4'd5;
  localparam logic [3:0] S_PUSH   = 4'd6;
  localparam logic [3:0] S_NEXT   = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [11:0]       instr_q, instr_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] alu_y;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [4:0]        shamt;

  assign opcode = instr_q[11:8];
  assign addr_a = instr_q[7:4];
  assign addr_b = instr_q[3:0];
  assign shamt  = rData[4:0];

  // Operand B comes straight from the register file port in EXEC.
  always_comb begin
    alu_y = '0;
    case (opcode)
      4'h1: alu_y = opa_q + rData;
      4'h2: alu_y = opa_q - rData;
      4'h3: alu_y = opa_q & rData;
      4'h4: alu_y = opa_q | rData;
      4'h5: alu_y = opa_q ^ rData;
      4'h6: alu_y = ~opa_q;
      4'h7: alu_y = opa_q << shamt;
      4'h8: alu_y = opa_q >> shamt;
      4'h9: alu_y = $signed(opa_q) >>> shamt;
      4'hA: alu_y = opa_q * rData;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    raddr_d = raddr_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (alu_begin)
          state_d = inst_empty ? S_DONE : S_POP;
      end
      state_q == S_POP: state_d = S_DECODE;
      state_q == S_DECODE: begin
        instr_d = inst_dout[15:4];
        state_d = S_RD_A;
      end
      state_q == S_RD_A: begin
        raddr_d = addr_a;
        state_d = S_RD_B;
      end
      state_q == S_RD_B: begin
        opa_d   = rData;
        raddr_d = addr_b;
        state_d = S_EXEC;
      end
      state_q == S_EXEC: begin
        opb_d   = rData;
        res_d   = alu_y;
        state_d = S_PUSH;
      end
      state_q == S_PUSH: begin
        if (!r_full)
          state_d = S_NEXT;
      end
      state_q == S_NEXT: begin
        state_d = inst_empty ? S_DONE : S_POP;
      end
      state_q == S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      raddr_q <= raddr_d;
    end
  end

  assign inst_rd_en = (state_q == S_POP);
  assign re         = (state_q == S_RD_A) || (state_q == S_RD_B);
  assign rAddr      = raddr_d;
  assign r_wr_en    = (state_q == S_PUSH) && !r_full;
  assign r_din      = res_q;
  assign op_done    = (state_q == S_DONE);

  logic unused_ok;
  assign unused_ok = ^{inst_dout[DATA_W-1:16], inst_dout[3:0], opb_q};

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with FIFO and register file models
// and a behavioural ALU reference.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_begin = 1'b0;
  logic        inst_empty = 1'b1;
  logic [31:0] inst_dout = '0;
  logic        inst_rd_en;
  logic        re;
  logic [3:0]  rAddr;
  logic [31:0] rData = '0;
  logic        r_full = 1'b0;
  logic        r_wr_en;
  logic [31:0] r_din;
  logic        op_done;

  int vecs = 0;
  int errs = 0;
  int done_seen = 0;

  logic [31:0] iq[$];
  logic [31:0] exp_q[$];
  logic [31:0] regs[16];

  alu_exec_ctrl #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .alu_begin(alu_begin),
    .inst_empty(inst_empty), .inst_dout(inst_dout),
    .inst_rd_en(inst_rd_en), .re(re), .rAddr(rAddr),
    .rData(rData), .r_full(r_full), .r_wr_en(r_wr_en),
    .r_din(r_din), .op_done(op_done)
  );

  always #5 clk = ~clk;

  // instruction FIFO and register file models
  always @(posedge clk) begin
    if (inst_rd_en && iq.size() > 0)
      inst_dout <= iq.pop_front();
    inst_empty <= (iq.size() == 0);
    if (re)
      rData <= regs[rAddr];
  end

  // monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (inst_rd_en && inst_empty) begin
        errs++;
        $display("FAIL pop_when_empty: rd_en=1 empty=1 required rd_en=0");
      end
      if (r_wr_en && r_full) begin
        errs++;
        $display("FAIL push_when_full: wr_en=1 full=1 required wr_en=0");
      end
      if (r_wr_en) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_push: r_din=%h required no push", r_din);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (r_din !== e) begin
            errs++;
            $display("FAIL result: r_din=%h required %h", r_din, e);
          end
        end
      end
      if (op_done) begin
        vecs++;
        done_seen++;
        if (exp_q.size() != iq.size()) begin
          errs++;
          $display("FAIL done_early: pending results %0d required %0d",
                   exp_q.size(), iq.size());
        end
      end
    end
  end

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned p;
    int s;
    s = int'(b % 32);
    case (op)
      4'h1: return a + b;
      4'h2: return a - b;
      4'h3: return a & b;
      4'h4: return a | b;
      4'h5: return a ^ b;
      4'h6: return ~a;
      4'h7: return a << s;
      4'h8: return a >> s;
      4'h9: return a[31] ? ~((~a) >> s) : (a >> s);
      4'hA: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_raw(input logic [3:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [31:0] e);
    logic [31:0] ins;
    ins = $urandom;
    ins[15:4] = {op, a, b};
    iq.push_back(ins);
    exp_q.push_back(e);
  endtask

  task automatic push_inst(input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b);
    push_raw(op, a, b, model(op, regs[a], regs[b]));
  endtask

  // rmode 0: r_full low; 1: random r_full; midp: inject an extra instr
  task automatic go(input int rmode, input bit midp);
    int start;
    int cyc;
    start = done_seen;
    tick();
    alu_begin = 1'b1;
    tick();
    alu_begin = 1'b0;
    cyc = 0;
    while (done_seen == start && cyc < 400) begin
      if (rmode == 1) r_full = ($urandom_range(0, 2) == 0);
      if (midp && cyc == 8)
        push_inst(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom));
      tick();
      cyc++;
    end
    r_full = 1'b0;
    if (done_seen == start) begin
      errs++;
      vecs++;
      $display("FAIL batch_timeout: no op_done after %0d cycles", cyc);
    end
    repeat (4) tick();
    vecs++;
    if (done_seen != start + 1) begin
      errs++;
      $display("FAIL done_count: %0d pulses required 1", done_seen - start);
    end
  endtask

  task automatic chk_zero(input string nm);
    vecs++;
    if ({inst_rd_en, re, rAddr, r_wr_en, r_din, op_done} !== '0) begin
      errs++;
      $display("FAIL %s: rd=%b re=%b ad=%h wr=%b din=%h dn=%b required 0",
               nm, inst_rd_en, re, rAddr, r_wr_en, r_din, op_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = '0;
    repeat (2) tick();
    chk_zero("reset_state");
    reset_n = 1'b1;
    tick();

    regs[1] = 32'd5;
    regs[2] = 32'd7;
    push_raw(4'h1, 4'd1, 4'd2, 32'd12);
    go(0, 1'b0);

    regs[3] = 32'd0;
    regs[4] = 32'd1;
    regs[5] = 32'h8000_0000;
    regs[6] = 32'd4;
    push_raw(4'h2, 4'd3, 4'd4, 32'hFFFF_FFFF);
    push_raw(4'h9, 4'd5, 4'd6, 32'hF800_0000);
    go(0, 1'b0);

    push_raw(4'h1, 4'd1, 4'd2, 32'd12);
    push_raw(4'h5, 4'd1, 4'd2, 32'd2);
    push_raw(4'hF, 4'd1, 4'd2, 32'd0);
    go(0, 1'b0);

    // result FIFO full across the push
    push_raw(4'h6, 4'd3, 4'd3, 32'hFFFF_FFFF);
    r_full = 1'b1;
    tick();
    alu_begin = 1'b1;
    tick();
    alu_begin = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 8 || k == 12) begin
        vecs++;
        if (r_din !== 32'hFFFF_FFFF) begin
          errs++;
          $display("FAIL stall_hold: r_din=%h required ffffffff", r_din);
        end
      end
    end
    vecs++;
    if (exp_q.size() != 1) begin
      errs++;
      $display("FAIL stall_push: pending=%0d required 1", exp_q.size());
    end
    r_full = 1'b0;
    repeat (10) tick();

    go(0, 1'b0);

    // reset asserted during EXEC
    push_raw(4'h1, 4'd1, 4'd2, 32'd12);
    tick();
    alu_begin = 1'b1;
    tick();
    alu_begin = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk_zero("reset_in_exec");
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    push_raw(4'hA, 4'd1, 4'd2, 32'd35);
    go(0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      int n;
      if (iq.size() == 0)
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
      n = $urandom_range(0, 4);
      for (int j = 0; j < n; j++)
        push_inst(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom));
      go($urandom_range(0, 1), ($urandom_range(0, 3) == 0));
    end
    if (iq.size() != 0) go(0, 1'b0);

    vecs++;
    if (exp_q.size() != 0 || iq.size() != 0) begin
      errs++;
      $display("FAIL drain: pending=%0d queued=%0d required 0",
               exp_q.size(), iq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
